// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t IDLE  = 2'd0;
   localparam arb_state_t ISSUE = 2'd1;
   localparam arb_state_t RESP  = 2'd2;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

   localparam int unsigned WORD_BYTES = 4;

   // Word-aligned and the last byte inside memory; 65-bit sum so a high address cannot wrap.
   function automatic logic addr_legal(input logic [63:0] addr, input int unsigned mem_bytes);
      logic [64:0] last_byte;
      last_byte = {1'b0, addr} + 65'(WORD_BYTES - 1);
      return (addr[1:0] == 2'b00) && (last_byte < 65'(mem_bytes));
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response channels for fetch and data plus the memory-side bus of the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [31:0]       if_rsp_data;
   logic              if_rsp_err;

   logic              dm_req_valid;
   logic              dm_req_ready;
   logic              dm_req_we;
   logic [ADDR_W-1:0] dm_req_addr;
   logic [31:0]       dm_req_wdata;
   logic              dm_rsp_valid;
   logic              dm_rsp_ready;
   logic [31:0]       dm_rsp_data;
   logic              dm_rsp_err;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  if_req_valid, if_req_addr, if_rsp_ready,
      input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_rsp_ready,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req_valid, if_req_addr, if_rsp_ready,
      output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_rsp_ready,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
      input  mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin picker between fetch and data requesters.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   req_if_i,
   input  logic   req_dm_i,
   input  logic   accept_i,
   output grant_t grant_o,
   output grant_t last_grant_o
);

   grant_t last_q;

   always_comb begin
      grant_o = GNT_IF;
      if (req_if_i && req_dm_i) begin
         grant_o = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
      end else if (req_dm_i) begin
         grant_o = GNT_DM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= GNT_DM;
      end else if (accept_i) begin
         last_q <= grant_o;
      end
   end

   assign last_grant_o = last_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between fetch and data requesters.
// Optional MEMARB_PERF_CNT_EN adds saturating grant/conflict counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus,
   output logic                busy
`ifdef MEMARB_PERF_CNT_EN
   ,
   output logic [15:0]         perf_if_grants,
   output logic [15:0]         perf_dm_grants,
   output logic [15:0]         perf_conflicts
`endif
);

   arb_state_t        state_q, state_d;
   grant_t            gnt_q;
   grant_t            grant;
   grant_t            last_grant;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic              idle;
   logic              accept;
   logic              legal;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [31:0]       sel_wdata;
   logic              in_resp;
   logic              rsp_hs;
   logic [31:0]       rsp_data;

   mem_arb_rr u_rr (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_if_i     (bus.if_req_valid),
      .req_dm_i     (bus.dm_req_valid),
      .accept_i     (accept),
      .grant_o      (grant),
      .last_grant_o (last_grant)
   );

   assign idle      = (state_q == IDLE);
   assign accept    = idle && ((grant == GNT_IF) ? bus.if_req_valid : bus.dm_req_valid);
   assign sel_addr  = (grant == GNT_IF) ? bus.if_req_addr : bus.dm_req_addr;
   assign sel_we    = (grant == GNT_DM) && bus.dm_req_we;
   assign sel_wdata = (grant == GNT_DM) ? bus.dm_req_wdata : 32'h0;
   assign legal     = addr_legal(64'(sel_addr), MEM_BYTES);

   assign in_resp = (state_q == RESP);
   assign rsp_hs  = in_resp && ((gnt_q == GNT_IF) ? bus.if_rsp_ready : bus.dm_rsp_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = legal ? ISSUE : RESP;
         ISSUE:   state_d = RESP;
         RESP:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-side address/data only move on legal requests so rdata stays stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_DM;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gnt_q <= grant;
            we_q  <= sel_we;
            err_q <= !legal;
            if (legal) begin
               mem_addr_q  <= sel_addr;
               mem_wdata_q <= sel_wdata;
            end
         end
      end
   end

   assign bus.if_req_ready = accept && (grant == GNT_IF);
   assign bus.dm_req_ready = accept && (grant == GNT_DM);

   assign bus.mem_we    = (state_q == ISSUE) && we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign rsp_data = err_q ? 32'h0 : bus.mem_rdata;

   assign bus.if_rsp_valid = in_resp && (gnt_q == GNT_IF);
   assign bus.if_rsp_data  = bus.if_rsp_valid ? rsp_data : 32'h0;
   assign bus.if_rsp_err   = bus.if_rsp_valid && err_q;
   assign bus.dm_rsp_valid = in_resp && (gnt_q == GNT_DM);
   assign bus.dm_rsp_data  = bus.dm_rsp_valid ? rsp_data : 32'h0;
   assign bus.dm_rsp_err   = bus.dm_rsp_valid && err_q;

   assign busy = !idle;

`ifdef MEMARB_PERF_CNT_EN
   logic [15:0] if_cnt_q, dm_cnt_q, cf_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_cnt_q <= '0;
         dm_cnt_q <= '0;
         cf_cnt_q <= '0;
      end else begin
         if (bus.if_req_ready && (if_cnt_q != 16'hFFFF)) if_cnt_q <= if_cnt_q + 16'd1;
         if (bus.dm_req_ready && (dm_cnt_q != 16'hFFFF)) dm_cnt_q <= dm_cnt_q + 16'd1;
         if (idle && bus.if_req_valid && bus.dm_req_valid && (cf_cnt_q != 16'hFFFF)) begin
            cf_cnt_q <= cf_cnt_q + 16'd1;
         end
      end
   end

   assign perf_if_grants = if_cnt_q;
   assign perf_dm_grants = dm_cnt_q;
   assign perf_conflicts = cf_cnt_q;
`endif

   logic unused_last_grant;
   assign unused_last_grant = (last_grant == GNT_IF);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first synchronous memory model.
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;
   logic busy;
`ifdef MEMARB_PERF_CNT_EN
   logic [15:0] perf_if_grants, perf_dm_grants, perf_conflicts;
`endif

   int n_cmp;
   int n_bad;
   int we_cnt;
   int w0;

   logic [31:0] mem [0:255];

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();

   mem_port_arbiter #(
      .MEM_BYTES (1024),
      .ADDR_W    (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .busy           (busy)
`ifdef MEMARB_PERF_CNT_EN
      ,
      .perf_if_grants (perf_if_grants),
      .perf_dm_grants (perf_dm_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first single-port memory: a store's own read returns the new word.
   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
         bus.mem_rdata          <= bus.mem_wdata;
         we_cnt                 <= we_cnt + 1;
      end else begin
         bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] ill_addr [4];
   logic        ill_err  [4];
   logic [31:0] ill_madr [4];
   logic        exp_if;

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      we_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h1122_3344;
      mem[255] = 32'hA5A5_0FF0;
      bus.mem_rdata = 32'h0;

      ill_addr = '{32'h0000_03FD, 32'h0000_0002, 32'h0000_03FC, 32'hFFFF_FFFC};
      ill_err  = '{1'b1, 1'b1, 1'b0, 1'b1};
      ill_madr = '{32'h0000_0004, 32'h0000_0004, 32'h0000_03FC, 32'h0000_03FC};

      rst_n = 1'b0;
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = 32'h0;
      bus.if_rsp_ready = 1'b0;
      bus.dm_req_valid = 1'b0;
      bus.dm_req_we    = 1'b0;
      bus.dm_req_addr  = 32'h0;
      bus.dm_req_wdata = 32'h0;
      bus.dm_rsp_ready = 1'b0;
      #1;
      chk("rst_if_req_ready", bus.if_req_ready, 0);
      chk("rst_dm_req_ready", bus.dm_req_ready, 0);
      chk("rst_if_rsp_valid", bus.if_rsp_valid, 0);
      chk("rst_dm_rsp_valid", bus.dm_rsp_valid, 0);
      chk("rst_dm_rsp_data",  bus.dm_rsp_data, 0);
      chk("rst_mem_we",       bus.mem_we, 0);
      chk("rst_mem_addr",     bus.mem_addr, 0);
      chk("rst_mem_wdata",    bus.mem_wdata, 0);
      chk("rst_busy",         busy, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Plain fetch of address 0.
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0;
      #1;
      chk("f_req_ready_c0", bus.if_req_ready, 1);
      tick();
      bus.if_req_valid = 1'b0;
      #1;
      chk("f_busy_c1", busy, 1);
      chk("f_rsp_valid_c1", bus.if_rsp_valid, 0);
      chk("f_req_ready_c1", bus.if_req_ready, 0);
      tick();
      chk("f_rsp_valid_c2", bus.if_rsp_valid, 1);
      chk("f_rsp_data_c2", bus.if_rsp_data, 32'h1122_3344);
      chk("f_rsp_err_c2", bus.if_rsp_err, 0);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;
      #1;
      chk("f_busy_done", busy, 0);
      chk("f_rsp_valid_done", bus.if_rsp_valid, 0);

      // Store then load back.
      w0 = we_cnt;
      bus.dm_req_valid = 1'b1;
      bus.dm_req_we    = 1'b1;
      bus.dm_req_addr  = 32'h4;
      bus.dm_req_wdata = 32'hFFFF_4455;
      #1;
      chk("st_req_ready", bus.dm_req_ready, 1);
      chk("st_if_ready", bus.if_req_ready, 0);
      tick();
      bus.dm_req_valid = 1'b0;
      bus.dm_req_we    = 1'b0;
      #1;
      chk("st_mem_we_issue", bus.mem_we, 1);
      chk("st_mem_addr", bus.mem_addr, 32'h4);
      chk("st_mem_wdata", bus.mem_wdata, 32'hFFFF_4455);
      tick();
      chk("st_mem_we_resp", bus.mem_we, 0);
      chk("st_rsp_valid", bus.dm_rsp_valid, 1);
      chk("st_rsp_data", bus.dm_rsp_data, 32'hFFFF_4455);
      chk("st_if_rsp_valid", bus.if_rsp_valid, 0);
      chk("st_if_rsp_data", bus.if_rsp_data, 0);
      bus.dm_rsp_ready = 1'b1;
      tick();
      bus.dm_rsp_ready = 1'b0;
      #1;
      chk("st_we_cycles", 32'(we_cnt - w0), 1);

      bus.dm_req_valid = 1'b1;
      bus.dm_req_addr  = 32'h4;
      #1;
      chk("ld_req_ready", bus.dm_req_ready, 1);
      tick();
      bus.dm_req_valid = 1'b0;
      #1;
      chk("ld_mem_we", bus.mem_we, 0);
      tick();
      chk("ld_rsp_valid", bus.dm_rsp_valid, 1);
      chk("ld_rsp_data", bus.dm_rsp_data, 32'hFFFF_4455);
      chk("ld_rsp_err", bus.dm_rsp_err, 0);
      bus.dm_rsp_ready = 1'b1;
      tick();
      bus.dm_rsp_ready = 1'b0;

      // Range/alignment boundaries.
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         bus.dm_req_valid = 1'b1;
         bus.dm_req_addr  = ill_addr[i];
         #1;
         chk("ill_req_ready", bus.dm_req_ready, 1);
         tick();
         bus.dm_req_valid = 1'b0;
         #1;
         if (ill_err[i]) begin
            chk("ill_rsp_valid_c1", bus.dm_rsp_valid, 1);
            chk("ill_rsp_err", bus.dm_rsp_err, 1);
            chk("ill_rsp_data", bus.dm_rsp_data, 0);
         end else begin
            chk("edge_rsp_valid_c1", bus.dm_rsp_valid, 0);
            tick();
            chk("edge_rsp_valid_c2", bus.dm_rsp_valid, 1);
            chk("edge_rsp_err", bus.dm_rsp_err, 0);
            chk("edge_rsp_data", bus.dm_rsp_data, 32'hA5A5_0FF0);
         end
         chk("ill_mem_addr_hold", bus.mem_addr, ill_madr[i]);
         bus.dm_rsp_ready = 1'b1;
         tick();
         bus.dm_rsp_ready = 1'b0;
         #1;
         chk("ill_no_write", 32'(we_cnt - w0), 0);
      end

      // Response backpressure with a competing fetch waiting.
      bus.dm_req_valid = 1'b1;
      bus.dm_req_addr  = 32'h4;
      #1;
      chk("bp_req_ready", bus.dm_req_ready, 1);
      tick();
      bus.dm_req_valid = 1'b0;
      bus.dm_req_addr  = 32'h0;
      tick();
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("bp_rsp_valid", bus.dm_rsp_valid, 1);
         chk("bp_rsp_data", bus.dm_rsp_data, 32'hFFFF_4455);
         chk("bp_if_req_ready", bus.if_req_ready, 0);
         chk("bp_busy", busy, 1);
         tick();
      end
      bus.dm_rsp_ready = 1'b1;
      tick();
      bus.dm_rsp_ready = 1'b0;
      #1;
      chk("bp_if_ready_after", bus.if_req_ready, 1);
      tick();
      bus.if_req_valid = 1'b0;
      tick();
      chk("bp_fetch_data", bus.if_rsp_data, 32'h1122_3344);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;

      // Asynchronous reset in the middle of a store's ISSUE cycle.
      bus.dm_req_valid = 1'b1;
      bus.dm_req_we    = 1'b1;
      bus.dm_req_addr  = 32'h8;
      bus.dm_req_wdata = 32'hDEAD_BEEF;
      #1;
      chk("ar_req_ready", bus.dm_req_ready, 1);
      tick();
      bus.dm_req_valid = 1'b0;
      bus.dm_req_we    = 1'b0;
      #1;
      chk("ar_mem_we_before", bus.mem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_mem_we", bus.mem_we, 0);
      chk("ar_busy", busy, 0);
      chk("ar_rsp_valid", bus.dm_rsp_valid, 0);
      chk("ar_mem_addr", bus.mem_addr, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Both requesters valid continuously: fetch first, then strict alternation.
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0;
      bus.dm_req_valid = 1'b1;
      bus.dm_req_addr  = 32'h0;
      bus.if_rsp_ready = 1'b1;
      bus.dm_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_if = ((k % 2) == 0);
         #1;
         chk("alt_if_ready", bus.if_req_ready, 32'(exp_if));
         chk("alt_dm_ready", bus.dm_req_ready, 32'(!exp_if));
         tick();
         tick();
         chk("alt_if_rsp_valid", bus.if_rsp_valid, 32'(exp_if));
         chk("alt_dm_rsp_valid", bus.dm_rsp_valid, 32'(!exp_if));
         chk("alt_data", exp_if ? bus.if_rsp_data : bus.dm_rsp_data, 32'h1122_3344);
         tick();
      end
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
      bus.if_rsp_ready = 1'b0;
      bus.dm_rsp_ready = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
